// File: rtl/xras_sla_pkg.sv
// Shared types and helpers for the XRAS SLA escalation block.
package xras_sla_pkg;

  typedef enum logic [7:0] {
    ACTIVE   = 8'd0,
    WARNING  = 8'd1,
    BREACHED = 8'd2
  } sla_status_e;

  typedef enum logic [1:0] {
    SEV_NONE  = 2'd0,
    SEV_MINOR = 2'd1,
    SEV_MAJOR = 2'd2,
    SEV_CRIT  = 2'd3
  } esc_severity_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    ISSUE    = 2'd2,
    COOLDOWN = 2'd3
  } esc_state_e;

  localparam int unsigned SEV_MAJOR_GAP = 64;
  localparam int unsigned SEV_CRIT_GAP  = 256;

  typedef struct packed {
    logic [7:0]    level;
    logic [31:0]   id;
    esc_severity_e severity;
    logic [31:0]   penalty;
  } esc_record_t;

  function automatic esc_severity_e gap_severity(input logic [31:0] gap);
    if (gap >= 32'(SEV_CRIT_GAP)) return SEV_CRIT;
    if (gap >= 32'(SEV_MAJOR_GAP)) return SEV_MAJOR;
    return SEV_MINOR;
  endfunction

  function automatic logic [31:0] sat_penalty(input logic [31:0] gap, input logic [31:0] weight);
    logic [63:0] prod;
    prod = 64'(gap) * 64'(weight);
    return (|prod[63:32]) ? 32'hFFFF_FFFF : prod[31:0];
  endfunction

endpackage

// File: rtl/xras_sla_escalation_if.sv
// Escalation record channel (valid/ready) towards the remediation/billing layer.
interface xras_sla_escalation_if;
  logic        esc_valid;
  logic        esc_ready;
  logic [7:0]  esc_level;
  logic [31:0] esc_sla_id;
  logic [1:0]  esc_severity;
  logic [31:0] esc_penalty;

  modport master (
    output esc_valid, esc_level, esc_sla_id, esc_severity, esc_penalty,
    input  esc_ready
  );

  modport slave (
    input  esc_valid, esc_level, esc_sla_id, esc_severity, esc_penalty,
    output esc_ready
  );
endinterface

// File: rtl/xras_sla_breach_tracker.sv
// One SLA level: consecutive-breach counter, pending flag and latched trigger slot.
module xras_sla_breach_tracker
  import xras_sla_pkg::*;
#(
  parameter int unsigned BREACH_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit,
  input  logic [7:0]  status,
  input  logic [31:0] gap,
  input  logic [31:0] id,
  input  logic [31:0] weight,
  input  logic        take,
  output logic        pend,
  output logic [31:0] slot_gap,
  output logic [31:0] slot_id,
  output logic [31:0] slot_weight
);

  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        pend_q, pend_d;
  logic        trig;
  logic [31:0] gap_q, id_q, weight_q;

  always_comb begin
    cnt_d   = cnt_q;
    pend_d  = pend_q & ~take;
    trig    = 1'b0;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    if (hit) begin
      case (sla_status_e'(status))
        BREACHED: begin
          if (cnt_inc == 8'(BREACH_THRESH)) begin
            trig   = 1'b1;
            cnt_d  = 8'd0;
            // A new trigger wins over a same-cycle take: it is a fresh record.
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ACTIVE:  cnt_d = 8'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 8'd0;
      pend_q   <= 1'b0;
      gap_q    <= 32'd0;
      id_q     <= 32'd0;
      weight_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (trig) begin
        gap_q    <= gap;
        id_q     <= id;
        weight_q <= weight;
      end
    end
  end

  assign pend        = pend_q;
  assign slot_gap    = gap_q;
  assign slot_id     = id_q;
  assign slot_weight = weight_q;

endmodule

// File: rtl/xras_sla_escalation.sv
// SLA breach escalation: per-level breach trackers feeding a single issue FSM.
// Optional XRAS_SLA_ESC_STATS_EN adds esc_total / drop_count statistics ports.
module xras_sla_escalation
  import xras_sla_pkg::*;
#(
  parameter int unsigned NUM_LEVELS      = 6,
  parameter int unsigned BREACH_THRESH   = 3,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           sla_id,
  input  logic [31:0]           reliability_gap,
  input  logic [7:0]            sla_status,
  input  logic                  sla_updated,
  input  logic [31:0]           financial_weight,
  xras_sla_escalation_if.master esc,
  output logic                  busy
`ifdef XRAS_SLA_ESC_STATS_EN
  ,
  output logic [15:0]           esc_total,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned CdW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  logic [7:0]            lvl;
  logic                  in_range;
  logic [NUM_LEVELS-1:0] pend, take, sel_onehot;
  logic [31:0]           slot_gap [NUM_LEVELS];
  logic [31:0]           slot_id [NUM_LEVELS];
  logic [31:0]           slot_weight [NUM_LEVELS];

  assign lvl      = sla_id[31:24];
  assign in_range = 32'(lvl) < NUM_LEVELS;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_track
    xras_sla_breach_tracker #(
      .BREACH_THRESH(BREACH_THRESH)
    ) u_track (
      .clk        (clk),
      .rst_n      (rst_n),
      .hit        (sla_updated && in_range && (lvl == 8'(g))),
      .status     (sla_status),
      .gap        (reliability_gap),
      .id         (sla_id),
      .weight     (financial_weight),
      .take       (take[g]),
      .pend       (pend[g]),
      .slot_gap   (slot_gap[g]),
      .slot_id    (slot_id[g]),
      .slot_weight(slot_weight[g])
    );
  end

  // Highest-index pending level wins; the last match in the ascending loop is kept.
  logic        any_pend;
  logic [7:0]  sel_lvl;
  logic [31:0] sel_gap, sel_id, sel_weight;

  always_comb begin
    any_pend   = 1'b0;
    sel_onehot = '0;
    sel_lvl    = 8'd0;
    sel_gap    = 32'd0;
    sel_id     = 32'd0;
    sel_weight = 32'd0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      if (pend[i]) begin
        any_pend      = 1'b1;
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_lvl       = 8'(i);
        sel_gap       = slot_gap[i];
        sel_id        = slot_id[i];
        sel_weight    = slot_weight[i];
      end
    end
  end

  esc_state_e  state_q, state_d;
  logic [7:0]  lvl_q, lvl_d;
  logic [31:0] gap_q, gap_d, id_q, id_d, weight_q, weight_d;
  esc_record_t rec_q, rec_d;
  logic [CdW-1:0] cd_q, cd_d;

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    gap_d    = gap_q;
    id_d     = id_q;
    weight_d = weight_q;
    rec_d    = rec_q;
    cd_d     = cd_q;
    take     = '0;
    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          // Snapshot the slot now so a same-cycle retrigger cannot alter this record.
          take     = sel_onehot;
          lvl_d    = sel_lvl;
          gap_d    = sel_gap;
          id_d     = sel_id;
          weight_d = sel_weight;
          state_d  = CALC;
        end
      end
      CALC: begin
        rec_d.level    = lvl_q;
        rec_d.id       = id_q;
        rec_d.severity = gap_severity(gap_q);
        rec_d.penalty  = sat_penalty(gap_q, weight_q);
        state_d        = ISSUE;
      end
      ISSUE: begin
        if (esc.esc_ready) begin
          cd_d    = '0;
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cd_q == CdW'(COOLDOWN_CYCLES - 1)) state_d = IDLE;
        else cd_d = cd_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lvl_q    <= 8'd0;
      gap_q    <= 32'd0;
      id_q     <= 32'd0;
      weight_q <= 32'd0;
      rec_q    <= '0;
      cd_q     <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      gap_q    <= gap_d;
      id_q     <= id_d;
      weight_q <= weight_d;
      rec_q    <= rec_d;
      cd_q     <= cd_d;
    end
  end

  assign esc.esc_valid    = (state_q == ISSUE);
  assign esc.esc_level    = rec_q.level;
  assign esc.esc_sla_id   = rec_q.id;
  assign esc.esc_severity = rec_q.severity;
  assign esc.esc_penalty  = rec_q.penalty;
  assign busy             = (state_q != IDLE);

`ifdef XRAS_SLA_ESC_STATS_EN
  logic [15:0] total_q, drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= 16'd0;
      drop_q  <= 16'd0;
    end else begin
      if (esc.esc_valid && esc.esc_ready && total_q != 16'hFFFF) total_q <= total_q + 16'd1;
      if (sla_updated && !in_range && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign esc_total  = total_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_xras_sla_escalation.sv
// Self-checking bench: directed vector table, corner sequences, random traffic vs a cycle model.
module tb_xras_sla_escalation;

  localparam int NL = 6;
  localparam int TH = 3;
  localparam int CD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] sla_id = '0, gap = '0, wt = '0;
  logic [7:0]  st = '0;
  logic        upd = 1'b0;
  logic        busy;
`ifdef XRAS_SLA_ESC_STATS_EN
  logic [15:0] esc_total, drop_count;
`endif

  xras_sla_escalation_if esc ();

  xras_sla_escalation #(
    .NUM_LEVELS     (NL),
    .BREACH_THRESH  (TH),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sla_id          (sla_id),
    .reliability_gap (gap),
    .sla_status      (st),
    .sla_updated     (upd),
    .financial_weight(wt),
    .esc             (esc),
    .busy            (busy)
`ifdef XRAS_SLA_ESC_STATS_EN
    ,
    .esc_total       (esc_total),
    .drop_count      (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: per-level breach counts, pending records, and an engine
  // described by when its record becomes visible and when it is free again.
  int          m_cnt [NL];
  bit          m_pend [NL];
  logic [31:0] m_gap [NL], m_idr [NL], m_wt [NL];
  bit          m_sel;
  int          m_tval, m_free;
  logic [7:0]  e_lvl;
  logic [31:0] e_id, e_pen;
  logic [1:0]  e_sev;
  int          m_total, m_drop;
  int          cyc = 0;
  bit          prev_valid;
  logic [7:0]  xfer_lvl [$];
  logic [1:0]  xfer_sev [$];
  logic [31:0] xfer_pen [$];
  int          xfer_cyc [$];
  int          rise_cyc [$];

  function automatic logic [1:0] ref_sev(input logic [31:0] g);
    if (g >= 256) return 2'd3;
    if (g >= 64) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [31:0] ref_pen(input logic [31:0] g, input logic [31:0] w);
    longint unsigned p;
    p = longint'(g) * longint'(w);
    if (p > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return p[31:0];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_cnt[l] = 0; m_pend[l] = 0; m_gap[l] = '0; m_idr[l] = '0; m_wt[l] = '0;
    end
    m_sel = 0; m_tval = 0; m_free = 0; m_total = 0; m_drop = 0; prev_valid = 0;
  endtask

  task automatic step(input bit u, input logic [31:0] id, input logic [7:0] s,
                      input logic [31:0] g, input logic [31:0] w, input bit rdy);
    bit exp_busy, exp_valid, found;
    int lv;
    upd = u; sla_id = id; st = s; gap = g; wt = w; esc.esc_ready = rdy;
    #1;
    exp_busy  = m_sel || (cyc < m_free);
    exp_valid = m_sel && (cyc >= m_tval);
    chk("busy", busy, exp_busy);
    chk("esc_valid", esc.esc_valid, exp_valid);
    if (exp_valid) begin
      chk("esc_level", esc.esc_level, e_lvl);
      chk("esc_sla_id", esc.esc_sla_id, e_id);
      chk("esc_severity", esc.esc_severity, e_sev);
      chk("esc_penalty", esc.esc_penalty, e_pen);
    end
`ifdef XRAS_SLA_ESC_STATS_EN
    chk("esc_total", esc_total, m_total);
    chk("drop_count", drop_count, m_drop);
`endif
    if (esc.esc_valid && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid = esc.esc_valid;
    if (exp_valid && rdy) begin
      xfer_lvl.push_back(esc.esc_level);
      xfer_sev.push_back(esc.esc_severity);
      xfer_pen.push_back(esc.esc_penalty);
      xfer_cyc.push_back(cyc);
      m_sel  = 0;
      m_free = cyc + 1 + CD;
      if (m_total < 65535) m_total++;
    end
    if (!m_sel && cyc >= m_free) begin
      found = 0;
      for (int l = NL - 1; l >= 0; l--) begin
        if (!found && m_pend[l]) begin
          found = 1; m_pend[l] = 0; m_sel = 1; m_tval = cyc + 2;
          e_lvl = 8'(l); e_id = m_idr[l];
          e_sev = ref_sev(m_gap[l]); e_pen = ref_pen(m_gap[l], m_wt[l]);
        end
      end
    end
    if (u) begin
      lv = int'(id[31:24]);
      if (lv >= NL) begin
        if (m_drop < 65535) m_drop++;
      end else if (s == 8'd2) begin
        if (m_cnt[lv] < 255) m_cnt[lv]++;
        if (m_cnt[lv] == TH) begin
          m_cnt[lv] = 0; m_pend[lv] = 1;
          m_gap[lv] = g; m_idr[lv] = id; m_wt[lv] = w;
        end
      end else if (s == 8'd0) begin
        m_cnt[lv] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 32'd0, 8'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic breach(input logic [7:0] l, input logic [23:0] seq, input logic [31:0] g,
                        input logic [31:0] w, input bit rdy);
    step(1, {l, seq}, 8'd2, g, w, rdy);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, esc.esc_valid, 0);
    chk({tag, "_level"}, esc.esc_level, 0);
    chk({tag, "_id"}, esc.esc_sla_id, 0);
    chk({tag, "_sev"}, esc.esc_severity, 0);
    chk({tag, "_pen"}, esc.esc_penalty, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef XRAS_SLA_ESC_STATS_EN
    chk({tag, "_total"}, esc_total, 0);
    chk({tag, "_drop"}, drop_count, 0);
`endif
  endtask

  typedef struct {
    logic [7:0]  lvl;
    logic [31:0] g;
    logic [31:0] w;
    logic [1:0]  sev;
    logic [31:0] pen;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n0, c0, r0;
    logic [7:0] rl;
    logic [7:0] rs;
    int rsel;

    tbl[0] = '{8'd2, 32'd100, 32'd5, 2'd2, 32'd500};
    tbl[1] = '{8'd3, 32'd1000, 32'hFFFF_FFFF, 2'd3, 32'hFFFF_FFFF};
    tbl[2] = '{8'd0, 32'd63, 32'd2, 2'd1, 32'd126};
    tbl[3] = '{8'd5, 32'd64, 32'd0, 2'd2, 32'd0};
    tbl[4] = '{8'd1, 32'd256, 32'd16, 2'd3, 32'd4096};
    tbl[5] = '{8'd4, 32'd255, 32'd7, 2'd2, 32'd1785};
    tbl[6] = '{8'd0, 32'd1000, 32'h0041_8937, 2'd3, 32'hFFFF_FED8};
    tbl[7] = '{8'd2, 32'd2, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
    tbl[8] = '{8'd5, 32'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF};

    esc.esc_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    model_reset();

    // Single-level escalations from the vector table.
    for (int i = 0; i < 9; i++) begin
      n0 = xfer_lvl.size();
      for (int k = 0; k < TH; k++) breach(tbl[i].lvl, 24'(i * 16 + k), tbl[i].g, tbl[i].w, 1);
      c0 = cyc - 1;
      idle(4, 1);
      chk("tbl_xfer_count", xfer_lvl.size(), n0 + 1);
      if (xfer_lvl.size() > n0) begin
        chk("tbl_level", xfer_lvl[n0], tbl[i].lvl);
        chk("tbl_severity", xfer_sev[n0], tbl[i].sev);
        chk("tbl_penalty", xfer_pen[n0], tbl[i].pen);
        chk("tbl_latency", xfer_cyc[n0] - c0, 3);
      end
      idle(CD + 2, 1);
    end

    // Counter of level 2 restarts from zero after its escalation.
    n0 = xfer_lvl.size();
    breach(8'd2, 24'h200, 32'd100, 32'd5, 1);
    breach(8'd2, 24'h201, 32'd100, 32'd5, 1);
    idle(6, 1);
    chk("lvl2_cnt_cleared", xfer_lvl.size(), n0);
    step(1, {8'd2, 24'h202}, 8'd0, 32'd0, 32'd0, 1);

    // Level 1: B,B,A,B,B must not escalate; one more breach does.
    n0 = xfer_lvl.size();
    breach(8'd1, 24'h10, 32'd70, 32'd3, 1);
    breach(8'd1, 24'h11, 32'd70, 32'd3, 1);
    step(1, {8'd1, 24'h12}, 8'd0, 32'd70, 32'd3, 1);
    breach(8'd1, 24'h13, 32'd70, 32'd3, 1);
    step(1, {8'd1, 24'h14}, 8'd1, 32'd70, 32'd3, 1);
    breach(8'd1, 24'h15, 32'd70, 32'd3, 1);
    idle(6, 1);
    chk("lvl1_no_escalation", xfer_lvl.size(), n0);
    breach(8'd1, 24'h16, 32'd70, 32'd3, 1);
    idle(5, 1);
    chk("lvl1_escalation", xfer_lvl.size(), n0 + 1);
    if (xfer_lvl.size() > n0) chk("lvl1_level", xfer_lvl[n0], 1);
    idle(CD + 2, 1);

    // Levels 0 and 4 become pending while the engine is held busy: 4 goes first.
    n0 = xfer_lvl.size();
    r0 = rise_cyc.size();
    for (int k = 0; k < TH; k++) breach(8'd3, 24'(k), 32'd10, 32'd1, 0);
    for (int k = 0; k < TH; k++) breach(8'd0, 24'(k), 32'd20, 32'd2, 0);
    for (int k = 0; k < TH; k++) breach(8'd4, 24'(k), 32'd300, 32'd3, 0);
    idle(60, 1);
    chk("prio_xfer_count", xfer_lvl.size(), n0 + 3);
    chk("prio_rise_count", rise_cyc.size(), r0 + 3);
    if (xfer_lvl.size() >= n0 + 3) begin
      chk("prio_first", xfer_lvl[n0], 3);
      chk("prio_second", xfer_lvl[n0 + 1], 4);
      chk("prio_third", xfer_lvl[n0 + 2], 0);
    end
    if (rise_cyc.size() >= r0 + 3) chk("prio_spacing", rise_cyc[r0 + 2] - rise_cyc[r0 + 1], 3 + CD);

    // ready held low for 10+ cycles in ISSUE: record held, then exactly one transfer.
    n0 = xfer_lvl.size();
    r0 = rise_cyc.size();
    for (int k = 0; k < TH; k++) breach(8'd5, 24'h50 + 24'(k), 32'd1000, 32'hFFFF_FFFF, 0);
    idle(13, 0);
    chk("stall_no_xfer", xfer_lvl.size(), n0);
    chk("stall_valid_held", esc.esc_valid, 1);
    idle(1, 1);
    idle(2, 1);
    chk("stall_single_xfer", xfer_lvl.size(), n0 + 1);
    chk("stall_single_rise", rise_cyc.size(), r0 + 1);
    if (xfer_lvl.size() > n0) begin
      chk("stall_sev", xfer_sev[n0], 3);
      chk("stall_pen", xfer_pen[n0], 32'hFFFF_FFFF);
    end
    idle(CD + 2, 1);

    // Asynchronous reset while a record is offered.
    for (int k = 0; k < TH; k++) breach(8'd1, 24'h70 + 24'(k), 32'd500, 32'd3, 0);
    idle(4, 0);
    chk("pre_reset_valid", esc.esc_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Out-of-range level is dropped without any state change.
    n0 = xfer_lvl.size();
    breach(8'd9, 24'h1, 32'd500, 32'd3, 1);
    idle(2, 1);
`ifdef XRAS_SLA_ESC_STATS_EN
    chk("drop_count_one", drop_count, 1);
`endif
    breach(8'd9, 24'h2, 32'd500, 32'd3, 1);
    breach(8'd9, 24'h3, 32'd500, 32'd3, 1);
    idle(6, 1);
    chk("drop_no_xfer", xfer_lvl.size(), n0);
    chk("drop_not_busy", busy, 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rl   = 8'($urandom_range(0, 7));
      rsel = int'($urandom_range(0, 9));
      if (rsel < 6) rs = 8'd2;
      else if (rsel < 8) rs = 8'd0;
      else if (rsel == 8) rs = 8'd1;
      else rs = 8'($urandom_range(3, 255));
      step($urandom_range(0, 9) < 7, {rl, 24'($urandom)}, rs,
           ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1100)),
           ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 5000)),
           $urandom_range(0, 3) != 0);
    end
    idle(150, 1);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xras_sla_escalation.md
Name: xras_sla_escalation

Overview:
- Downstream consumer of the XRAS SLA orchestration stage. Monitors every SLA update (id, gap, status) and counts consecutive breaches per SLA level (device..cloud).
- When a level's count reaches a threshold, it issues one escalation record (level, id, severity, financial penalty) over a valid/ready interface to the remediation/billing layer. A cooldown follows each issued escalation.

Parameters:
- NUM_LEVELS, 6, number of SLA levels tracked (0:device .. 5:cloud)
- BREACH_THRESH, 3, consecutive breached updates that trigger escalation (1..255)
- COOLDOWN_CYCLES, 16, idle cycles enforced after each accepted escalation (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- sla_id  in  32  [31:24] = SLA level, [23:0] = sequence
- reliability_gap  in  32  target minus current reliability (0-1000 scale)
- sla_status  in  8  0 = active, 1 = warning, 2 = breached
- sla_updated  in  1  sample strobe; inputs valid when high
- financial_weight  in  32  penalty multiplier; sampled with the breach that triggers escalation
- esc_valid  out  1  escalation record valid
- esc_ready  in  1  consumer accepts record
- esc_level  out  8  level being escalated
- esc_sla_id  out  32  sla_id of the triggering breach
- esc_severity  out  2  1 = minor, 2 = major, 3 = critical
- esc_penalty  out  32  gap*weight, saturated
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. All per-level counters and pending bits cleared. FSM = IDLE.
- Input sampling, every cycle with sla_updated=1, in any FSM state:
  - lvl = sla_id[31:24].
  - lvl >= NUM_LEVELS: update is dropped.
  - status 2: cnt[lvl] increments, saturating at 255.
  - status 0: cnt[lvl] cleared.
  - status 1: cnt[lvl] held.
  - status >2: ignored.
- Trigger: the breach update that makes cnt[lvl] reach BREACH_THRESH:
  - sets pend[lvl];
  - latches gap, id, and weight into per-level slots;
  - clears cnt[lvl] in the same cycle.
  - A new trigger on an already-pending level overwrites its slot (latest wins).
- FSM states: IDLE, CALC, ISSUE, COOLDOWN.
  - IDLE: if any pend bit is set, select the highest-index pending level, clear its pend bit, go to CALC. A trigger arriving in the same cycle is visible the next cycle.
  - CALC, 1 cycle: penalty = 64-bit product gap*weight. If upper 32 bits are nonzero, penalty = 32'hFFFF_FFFF. Severity: gap >= 256 → 3; gap >= 64 → 2; else 1. Go to ISSUE.
  - ISSUE: esc_valid=1. All esc_* fields stay stable until esc_valid && esc_ready. Transfer occurs on that cycle; esc_valid drops next cycle. Go to COOLDOWN.
  - COOLDOWN: count COOLDOWN_CYCLES cycles, then go to IDLE.
- Latency: trigger sample → esc_valid high is 3 cycles (trigger registered, IDLE select, CALC), provided the FSM was IDLE.
- Throughput: at most one escalation per 3+COOLDOWN_CYCLES cycles. Pending levels are never lost; each level holds at most one pending record.
- busy = (state != IDLE).
- Reset mid-operation: any asserted esc_valid is abandoned immediately and all state is cleared.

Optional Feature:
- Macro XRAS_SLA_ESC_STATS_EN.
- Defined: adds output ports esc_total[15:0] (accepted escalations) and drop_count[15:0] (updates with an out-of-range level). Both saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package xras_sla_pkg holds:
  - sla_status_e enum (ACTIVE = 0, WARNING = 1, BREACHED = 2);
  - esc_severity_e;
  - esc_state_e (IDLE, CALC, ISSUE, COOLDOWN);
  - severity thresholds SEV_MAJOR_GAP = 64 and SEV_CRIT_GAP = 256;
  - esc_record_t struct (level, id, severity, penalty).
- One sub-module, xras_sla_breach_tracker, instantiated NUM_LEVELS times. Each instance holds one level's counter, pend bit, and latched slot.

Test Plan:
- Level 2: three status-2 updates with gap=100, weight=5 → esc_valid 3 cycles after the 3rd update with esc_level=2, severity=2, penalty=500. cnt[2]=0 afterwards.
- Level 1: sequence breach, breach, active, breach, breach → no escalation; the count restarts after the active update.
- Levels 0 and 4 trigger in the same window → level 4 is issued first. Level 0 is issued after COOLDOWN_CYCLES=16.
- esc_ready held low for 10 cycles in ISSUE → esc_* fields stable across all 10 cycles; a single transfer occurs when ready rises.
- gap=1000, weight=32'hFFFF_FFFF → esc_penalty=32'hFFFF_FFFF, severity=3.
- Update with sla_id[31:24]=9 → no state change; with XRAS_SLA_ESC_STATS_EN, drop_count=1. rst_n asserted while esc_valid=1 → all outputs 0 immediately.
